ascon_ctrl_seq: RTL

- Parametrised control sequencer for the Ascon AEAD datapath. Successor to the fixed 3-block controller.
- Owns the round counter internally and supports a runtime-programmable number of associated-data (AD) blocks and message blocks.
- Supports configurable p^a/p^b round counts, an explicit domain-separation step, and encrypt/decrypt mode.
- Drives the permutation enable, the upstream/downstream XOR selects and the state-register enable; handshakes block data with the bus side.

---
 rtl/ascon_ctrl_seq.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/ascon_ctrl_seq.sv
// ascon_ctrl_seq: control sequencer for the Ascon AEAD datapath
//
// Runs one AEAD operation per start request:
// p^a init, AD blocks, domain separation, message blocks, final key, p^a final, tag.
//
// Ports:
//   clock_i        clock
//   resetb_i       asynchronous reset, active-low
//   start_i        start request, sampled in IDLE only
//   decrypt_i      mode, latched at start (1 = decrypt)
//   nb_ad_i        AD block count, latched at start (0 allowed)
//   nb_data_i      message block count, latched at start (0 allowed)
//   data_valid_i   block data valid on the datapath input
//   data_ready_o   controller accepting a block this cycle
//   round_o        round-constant index for the permutation
//   perm_en_o      apply one permutation round this cycle
//   load_o         select IV||K||N as state-register input
//   xorup_sel_o    0 none, 1 data block, 2 key (pre-final)
//   xordn_sel_o    0 none, 1 key (post-perm), 2 domain-separation bit
//   ena_reg_o      state-register write enable
//   ad_phase_o     current/accepted block is AD
//   dec_mode_o     latched decrypt flag
//   cipher_valid_o ciphertext/plaintext block valid
//   tag_valid_o    tag valid, one-cycle pulse
//   busy_o         high in every state except IDLE
module ascon_ctrl_seq #(
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 6,
    parameter int BLK_W    = 8
) (
    input  logic             clock_i,
    input  logic             resetb_i,
    input  logic             start_i,
    input  logic             decrypt_i,
    input  logic [BLK_W-1:0] nb_ad_i,
    input  logic [BLK_W-1:0] nb_data_i,
    input  logic             data_valid_i,
    output logic             data_ready_o,
    output logic [3:0]       round_o,
    output logic             perm_en_o,
    output logic             load_o,
    output logic [1:0]       xorup_sel_o,
    output logic [1:0]       xordn_sel_o,
    output logic             ena_reg_o,
    output logic             ad_phase_o,
    output logic             dec_mode_o,
    output logic             cipher_valid_o,
    output logic             tag_valid_o,
    output logic             busy_o
);
    typedef enum logic [3:0] {
        IDLE, INIT, WAIT_AD, PB_AD, DOMSEP, WAIT_DATA, PB_DATA, FINAL_KEY, PA_FINAL, DONE
    } state_t;

    // Round counters always finish at 11, so shorter schedules start later.
    localparam logic [3:0] RND_A0 = 4'(12 - ROUNDS_A);
    localparam logic [3:0] RND_B0 = 4'(12 - ROUNDS_B);

    state_t           state_q, state_d;
    logic [3:0]       round_q, round_d;
    logic [BLK_W-1:0] ad_cnt_q, ad_cnt_d;
    logic [BLK_W-1:0] data_cnt_q, data_cnt_d;
    logic             dec_q, dec_d;
    logic             last_rnd;

    assign last_rnd   = round_q == 4'd11;
    assign round_o    = round_q;
    assign dec_mode_o = dec_q;
    assign busy_o     = state_q != IDLE;

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q    <= IDLE;
            round_q    <= '0;
            ad_cnt_q   <= '0;
            data_cnt_q <= '0;
            dec_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            round_q    <= round_d;
            ad_cnt_q   <= ad_cnt_d;
            data_cnt_q <= data_cnt_d;
            dec_q      <= dec_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        round_d        = round_q;
        ad_cnt_d       = ad_cnt_q;
        data_cnt_d     = data_cnt_q;
        dec_d          = dec_q;
        data_ready_o   = 1'b0;
        perm_en_o      = 1'b0;
        load_o         = 1'b0;
        xorup_sel_o    = 2'd0;
        xordn_sel_o    = 2'd0;
        ena_reg_o      = 1'b0;
        ad_phase_o     = 1'b0;
        cipher_valid_o = 1'b0;
        tag_valid_o    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d    = INIT;
                    round_d    = RND_A0;
                    dec_d      = decrypt_i;
                    ad_cnt_d   = nb_ad_i;
                    data_cnt_d = nb_data_i;
                end
            end
            INIT: begin
                perm_en_o   = 1'b1;
                ena_reg_o   = 1'b1;
                round_d     = round_q + 4'd1;
                // the first INIT round is the only one that still holds the start value
                load_o      = round_q == RND_A0;
                xordn_sel_o = last_rnd ? 2'd1 : 2'd0;
                if (last_rnd) state_d = ad_cnt_q != '0 ? WAIT_AD : DOMSEP;
            end
            WAIT_AD: begin
                data_ready_o = 1'b1;
                ad_phase_o   = 1'b1;
                ena_reg_o    = data_valid_i;
                xorup_sel_o  = data_valid_i ? 2'd1 : 2'd0;
                if (data_valid_i) begin
                    ad_cnt_d = ad_cnt_q - 1'b1;
                    round_d  = RND_B0;
                    state_d  = PB_AD;
                end
            end
            PB_AD: begin
                perm_en_o = 1'b1;
                ena_reg_o = 1'b1;
                round_d   = round_q + 4'd1;
                if (last_rnd) state_d = ad_cnt_q != '0 ? WAIT_AD : DOMSEP;
            end
            DOMSEP: begin
                xordn_sel_o = 2'd2;
                ena_reg_o   = 1'b1;
                state_d     = data_cnt_q != '0 ? WAIT_DATA : FINAL_KEY;
            end
            WAIT_DATA: begin
                data_ready_o   = 1'b1;
                ena_reg_o      = data_valid_i;
                cipher_valid_o = data_valid_i;
                xorup_sel_o    = data_valid_i ? 2'd1 : 2'd0;
                if (data_valid_i) begin
                    data_cnt_d = data_cnt_q - 1'b1;
                    // the last message block goes straight to finalisation without p^b
                    if (data_cnt_q == BLK_W'(1)) begin
                        state_d = FINAL_KEY;
                    end else begin
                        state_d = PB_DATA;
                        round_d = RND_B0;
                    end
                end
            end
            PB_DATA: begin
                perm_en_o = 1'b1;
                ena_reg_o = 1'b1;
                round_d   = round_q + 4'd1;
                if (last_rnd) state_d = WAIT_DATA;
            end
            FINAL_KEY: begin
                xorup_sel_o = 2'd2;
                ena_reg_o   = 1'b1;
                round_d     = RND_A0;
                state_d     = PA_FINAL;
            end
            PA_FINAL: begin
                perm_en_o   = 1'b1;
                ena_reg_o   = 1'b1;
                round_d     = round_q + 4'd1;
                xordn_sel_o = last_rnd ? 2'd1 : 2'd0;
                if (last_rnd) state_d = DONE;
            end
            DONE: begin
                tag_valid_o = 1'b1;
                // leave IDLE fully quiet: round index and mode return to zero
                round_d     = '0;
                dec_d       = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
